calc_seq_ctrl: RTL and testbench
================================

CALC_SEQ_CTRL -- requirements
Module: calc_seq_ctrl

Interface
REQ-001 SHALL have parameter DB_WIDTH, default 16, debounce counter width; a key is stable after 2^DB_WIDTH-1 consecutive equal samples.
REQ-002 SHALL have port CLK  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port RST_X  input  1  synchronous, active-high reset.
REQ-004 SHALL have port PSW  input  14  push switches, 1=pressed; [9:0] digits 0-9, [10] '+', [11] '-', [12] '=', [13] 'C'.
REQ-005 SHALL have port SUM_DATA  input  6  combinational A+B from the adder.
REQ-006 SHALL have port SUB_DATA  input  6  combinational A-B (two's complement) from the subtractor.
REQ-007 SHALL have port A_DATA  output  4  registered operand A to the datapath.
REQ-008 SHALL have port B_DATA  output  4  registered operand B to the datapath.
REQ-009 SHALL have port OP_SUB  output  1  registered operator; 0=add, 1=subtract.
REQ-010 SHALL have port RES_DATA  output  6  latched result.
REQ-011 SHALL have port RES_VALID  output  1  RES_DATA holds a completed result.
REQ-012 SHALL have port STATE  output  3  current FSM state, for display selection.

Function
REQ-013 SHALL pass each PSW bit through a 2-flop synchronizer, then the conditioner (REQ-030), and emit a 1-cycle press event on a 0->1 transition of the conditioned level.
REQ-014 SHALL accept at most one event per cycle: 'C' has top priority, then the lowest index among [12:0]; other events that cycle are discarded.
REQ-015 SHALL implement states IDLE, GOT_A, GOT_OP, GOT_B, EVAL, SHOW.
REQ-016 IDLE: digit d -> A_DATA=d, GOT_A; '+', '-', '=' are ignored.
REQ-017 GOT_A: digit d overwrites A_DATA; '+' or '-' sets OP_SUB and moves to GOT_OP; '=' is ignored.
REQ-018 GOT_OP: '+' or '-' overwrites OP_SUB; digit d -> B_DATA=d, GOT_B; '=' is ignored.
REQ-019 GOT_B: digit d overwrites B_DATA; '=' -> EVAL; '+' or '-' is ignored.
REQ-020 EVAL: lasts exactly one cycle and ignores all events; it latches RES_DATA = OP_SUB ? SUB_DATA : SUM_DATA, then moves to SHOW.
REQ-021 SHOW: RES_VALID=1; digit d -> A_DATA=d, B_DATA=0, RES_VALID=0, GOT_A; '+', '-', '=' are ignored.
REQ-022 'C' in any state -> IDLE with all outputs at reset values, in the cycle after the event.
REQ-023 A_DATA, B_DATA and OP_SUB SHALL be stable throughout EVAL, giving the datapath a full cycle of settle time.
REQ-024 Latency SHALL be 4 cycles from a PSW rise to the state/operand update when CALC_DEBOUNCE_EN is undefined: 2 sync, 1 edge, 1 FSM.
REQ-025 With the default encoding, the STATE encoding SHALL be IDLE=0, GOT_A=1, GOT_OP=2, GOT_B=3, EVAL=4, SHOW=5.

Reset
REQ-026 While RST_X=1 at a clock edge, the block SHALL take STATE=IDLE, A_DATA=0, B_DATA=0, OP_SUB=0, RES_DATA=0 and RES_VALID=0.
REQ-027 The same reset SHALL clear the synchronizers, conditioned levels and debounce counters to 0, so a key held through reset yields no event until released and pressed again.
REQ-028 Reset asserted mid-EVAL SHALL discard the pending result.

Configuration
REQ-029 Macro CALC_DEBOUNCE_EN SHALL select the key conditioner.
REQ-030 With CALC_DEBOUNCE_EN defined:
- the conditioned level changes only after the synced input differs from it for 2^DB_WIDTH-1 consecutive cycles;
- the counter clears whenever the input equals the level;
- REQ-024 latency grows by 2^DB_WIDTH-1 cycles.
REQ-031 Without CALC_DEBOUNCE_EN, the conditioned level SHALL equal the synchronizer output, and DB_WIDTH is unused.

Structure
REQ-032 Shared include calc_pkg SHALL hold the key index constants (KEY_PLUS=10, KEY_MINUS=11, KEY_EQ=12, KEY_CLR=13) and the state encodings.
REQ-033 Sub-module calc_key_cond SHALL implement one bit of sync, debounce and edge detection; calc_seq_ctrl instantiates it 14 times.
REQ-034 calc_seq_ctrl SHALL NOT instantiate the add or sub datapath; operands and results connect at the top level.

Verification (DB_WIDTH=2)
REQ-035 Press 3, '+', 5, '=' -> EVAL for one cycle, then SHOW; RES_DATA=8, OP_SUB=0, RES_VALID=1.
REQ-036 Press 2, '-', 7, '=' -> RES_DATA=6'b111011 (-5), OP_SUB=1.
REQ-037 Press 4, then 6 in GOT_A; '-' then '+' in GOT_OP -> A_DATA=6, OP_SUB=0; '=' pressed in GOT_OP leaves the state at GOT_OP.
REQ-038 PSW[13] and PSW[1] rise in the same cycle while in GOT_B -> IDLE with all outputs 0, and no digit is captured.
REQ-039 With CALC_DEBOUNCE_EN defined, a PSW[5] glitch high for 2 cycles -> no event; held high for 5 cycles -> exactly one event; with the macro undefined, the same 2-cycle glitch -> one event.
REQ-040 Hold PSW[4] high through a reset, then release reset -> no event; a new press after release and re-press -> A_DATA=4. In SHOW, pressing 9 -> GOT_A with A_DATA=9, RES_VALID=0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared key indices, FSM state encoding and key-event decode for the calculator sequencer.
package calc_pkg;

  localparam int NUM_KEYS  = 14;
  localparam int KEY_PLUS  = 10;
  localparam int KEY_MINUS = 11;
  localparam int KEY_EQ    = 12;
  localparam int KEY_CLR   = 13;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GOT_A  = 3'd1,
    ST_GOT_OP = 3'd2,
    ST_GOT_B  = 3'd3,
    ST_EVAL   = 3'd4,
    ST_SHOW   = 3'd5
  } calc_state_e;

  typedef struct packed {
    logic       clr;
    logic       is_digit;
    logic       is_op;
    logic       is_sub;
    logic       is_eq;
    logic [3:0] digit;
  } key_evt_t;

  // 'C' wins outright; otherwise the lowest set index is kept and the rest dropped.
  function automatic key_evt_t pick_event(input logic [NUM_KEYS-1:0] ev);
    key_evt_t k;
    k = '0;
    if (ev[KEY_CLR]) begin
      k.clr = 1'b1;
    end else begin
      for (int i = KEY_EQ; i >= 0; i--) begin
        if (ev[i]) begin
          k = '0;
          if (i < 10) begin
            k.is_digit = 1'b1;
            k.digit    = 4'(i);
          end else if (i == KEY_EQ) begin
            k.is_eq = 1'b1;
          end else begin
            k.is_op  = 1'b1;
            k.is_sub = (i == KEY_MINUS);
          end
        end
      end
    end
    return k;
  endfunction

endpackage

// File: rtl/calc_seq_ctrl_if.sv
// Operand/result bus between the sequencer and the external add/sub datapath.
interface calc_seq_ctrl_if;
  logic [3:0] A_DATA;
  logic [3:0] B_DATA;
  logic       OP_SUB;
  logic [5:0] SUM_DATA;
  logic [5:0] SUB_DATA;

  modport master (output A_DATA, B_DATA, OP_SUB, input SUM_DATA, SUB_DATA);
  modport slave  (input A_DATA, B_DATA, OP_SUB, output SUM_DATA, SUB_DATA);
endinterface

// File: rtl/calc_key_cond.sv
// One push-switch lane: 2-flop sync, optional debounce (CALC_DEBOUNCE_EN), rising-edge press pulse.
module calc_key_cond #(
  parameter int DB_WIDTH = 16
) (
  input  logic CLK,
  input  logic RST_X,
  input  logic key_raw,
  output logic press
);

  logic [1:0] sync_q;
  logic [1:0] valid_q;
  logic       level;
  logic       prev_q;
  logic       armed_q;

  always_ff @(posedge CLK) begin
    if (RST_X) begin
      sync_q  <= '0;
      valid_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], key_raw};
      valid_q <= {valid_q[0], 1'b1};
    end
  end

`ifdef CALC_DEBOUNCE_EN
  localparam logic [DB_WIDTH-1:0] DB_TC = DB_WIDTH'((1 << DB_WIDTH) - 2);

  logic [DB_WIDTH-1:0] db_cnt_q;
  logic                level_q;

  always_ff @(posedge CLK) begin
    if (RST_X) begin
      db_cnt_q <= '0;
      level_q  <= 1'b0;
    end else if (sync_q[1] == level_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_TC) begin
      level_q  <= sync_q[1];
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end
  end

  assign level = level_q;
`else
  assign level = sync_q[1];

  // Debounce width has no effect when the conditioner is a plain pass-through.
  if (DB_WIDTH < 1) begin : g_db_width_unused
  end
`endif

  // A lane only arms once it has seen a genuine released level after reset,
  // so a key held through reset cannot masquerade as a fresh press.
  always_ff @(posedge CLK) begin
    if (RST_X) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      prev_q <= level;
      if (valid_q[1] && !sync_q[1] && !level) armed_q <= 1'b1;
      press <= armed_q & level & ~prev_q;
    end
  end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator key sequencer: conditions 14 push switches and steps A op B = through the result FSM.
// Optional macro CALC_DEBOUNCE_EN enables the per-key debounce counter.
//
// state   | meaning
// IDLE    | waiting for first operand digit
// GOT_A   | operand A captured, digit overwrites, +/- selects operator
// GOT_OP  | operator captured, +/- overwrites, digit captures B
// GOT_B   | operand B captured, digit overwrites, '=' evaluates
// EVAL    | one cycle, datapath settles, result latched
// SHOW    | result valid, digit starts a new calculation
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int DB_WIDTH = 16
) (
  input  logic                CLK,
  input  logic                RST_X,
  input  logic [NUM_KEYS-1:0] PSW,
  calc_seq_ctrl_if.master     dp,
  output logic [5:0]          RES_DATA,
  output logic                RES_VALID,
  output logic [2:0]          STATE
);

  logic [NUM_KEYS-1:0] press;
  key_evt_t            evt;
  calc_state_e         state_q;
  logic [3:0]          a_q;
  logic [3:0]          b_q;
  logic                op_q;
  logic [5:0]          res_q;
  logic                res_valid_q;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    calc_key_cond #(.DB_WIDTH(DB_WIDTH)) u_key (
      .CLK     (CLK),
      .RST_X   (RST_X),
      .key_raw (PSW[i]),
      .press   (press[i])
    );
  end

  assign evt = pick_event(press);

  always_ff @(posedge CLK) begin
    if (RST_X || evt.clr) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (evt.is_digit) begin
            a_q     <= evt.digit;
            state_q <= ST_GOT_A;
          end
        end
        ST_GOT_A: begin
          if (evt.is_digit) begin
            a_q <= evt.digit;
          end else if (evt.is_op) begin
            op_q    <= evt.is_sub;
            state_q <= ST_GOT_OP;
          end
        end
        ST_GOT_OP: begin
          if (evt.is_op) begin
            op_q <= evt.is_sub;
          end else if (evt.is_digit) begin
            b_q     <= evt.digit;
            state_q <= ST_GOT_B;
          end
        end
        ST_GOT_B: begin
          if (evt.is_digit) begin
            b_q <= evt.digit;
          end else if (evt.is_eq) begin
            state_q <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          res_q       <= op_q ? dp.SUB_DATA : dp.SUM_DATA;
          res_valid_q <= 1'b1;
          state_q     <= ST_SHOW;
        end
        ST_SHOW: begin
          if (evt.is_digit) begin
            a_q         <= evt.digit;
            b_q         <= '0;
            res_valid_q <= 1'b0;
            state_q     <= ST_GOT_A;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dp.A_DATA = a_q;
  assign dp.B_DATA = b_q;
  assign dp.OP_SUB = op_q;
  assign RES_DATA  = res_q;
  assign RES_VALID = res_valid_q;
  assign STATE     = state_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl against a key-level calculator model.
module tb_calc_seq_ctrl;

  localparam int DBW = 2;
`ifdef CALC_DEBOUNCE_EN
  localparam int LAT = 4 + (1 << DBW) - 1;
`else
  localparam int LAT = 4;
`endif
  localparam int GAP = LAT + 3;

  logic        CLK = 1'b0;
  logic        RST_X;
  logic [13:0] PSW;
  logic [5:0]  RES_DATA;
  logic        RES_VALID;
  logic [2:0]  STATE;

  calc_seq_ctrl_if dp();

  assign dp.SUM_DATA = 6'(dp.A_DATA) + 6'(dp.B_DATA);
  assign dp.SUB_DATA = 6'(dp.A_DATA) - 6'(dp.B_DATA);

  calc_seq_ctrl #(.DB_WIDTH(DBW)) dut (
    .CLK       (CLK),
    .RST_X     (RST_X),
    .PSW       (PSW),
    .dp        (dp),
    .RES_DATA  (RES_DATA),
    .RES_VALID (RES_VALID),
    .STATE     (STATE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Calculator model: mode numbers follow the published display encoding.
  int m_state, m_a, m_b, m_op, m_res, m_valid;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_valid = 0;
  endtask

  task automatic model_key(input int k);
    if (k == 13) begin
      model_reset();
    end else if (k <= 9) begin
      if (m_state == 0 || m_state == 1) begin
        m_a = k; m_state = 1;
      end else if (m_state == 2 || m_state == 3) begin
        m_b = k; m_state = 3;
      end else if (m_state == 5) begin
        m_a = k; m_b = 0; m_valid = 0; m_state = 1;
      end
    end else if (k == 10 || k == 11) begin
      if (m_state == 1 || m_state == 2) begin
        m_op = (k == 11) ? 1 : 0; m_state = 2;
      end
    end else if (k == 12 && m_state == 3) begin
      m_state = 4;
    end
  endtask

  task automatic model_eval();
    m_res   = m_op ? ((m_a - m_b) & 63) : (m_a + m_b);
    m_valid = 1;
    m_state = 5;
  endtask

  function automatic logic [18:0] exp_vec();
    return {3'(m_state), 4'(m_a), 4'(m_b), 1'(m_op), 6'(m_res), 1'(m_valid)};
  endfunction

  function automatic logic [18:0] obs_vec();
    return {STATE, dp.A_DATA, dp.B_DATA, dp.OP_SUB, RES_DATA, RES_VALID};
  endfunction

  // Press a key, update the model at the point the FSM should react, release.
  task automatic do_key(input int k);
    PSW[k] = 1'b1;
    repeat (LAT) tick();
    model_key(k);
    if (m_state == 4) begin
      tick();
      model_eval();
    end
    PSW = '0;
    repeat (GAP) tick();
  endtask

  task automatic test_reset();
    PSW   = '0;
    RST_X = 1'b1;
    repeat (3) tick();
    model_reset();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", obs_vec(), exp_vec());
    end
    RST_X = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_add();
    PSW[3] = 1'b1;
    repeat (LAT - 1) tick();
    checks++;
    if (STATE !== 3'd0) begin
      errors++;
      $display("FAIL latency_early state got=%0d exp=0", STATE);
    end
    tick();
    model_key(3);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL latency_on_time got=%h exp=%h", obs_vec(), exp_vec());
    end
    PSW = '0;
    repeat (GAP) tick();
    do_key(10);
    do_key(5);
    PSW[12] = 1'b1;
    repeat (LAT) tick();
    model_key(12);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL add_eval_cycle got=%h exp=%h", obs_vec(), exp_vec());
    end
    tick();
    model_eval();
    checks++;
    if (obs_vec() !== exp_vec() || RES_DATA !== 6'd8) begin
      errors++;
      $display("FAIL add_show got=%h exp=%h res=%0d", obs_vec(), exp_vec(), RES_DATA);
    end
    PSW = '0;
    repeat (GAP) tick();
  endtask

  task automatic test_sub_and_restart();
    do_key(13);
    do_key(2); do_key(11); do_key(7); do_key(12);
    checks++;
    if (obs_vec() !== exp_vec() || RES_DATA !== 6'b111011 || dp.OP_SUB !== 1'b1) begin
      errors++;
      $display("FAIL sub_result got=%h exp=%h", obs_vec(), exp_vec());
    end
    do_key(9);
    checks++;
    if (obs_vec() !== exp_vec() || RES_VALID !== 1'b0 || dp.A_DATA !== 4'd9) begin
      errors++;
      $display("FAIL show_restart got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_overwrite();
    do_key(13);
    do_key(4); do_key(6); do_key(11); do_key(10); do_key(12);
    checks++;
    if (obs_vec() !== exp_vec() || STATE !== 3'd2 || dp.A_DATA !== 4'd6 || dp.OP_SUB !== 1'b0) begin
      errors++;
      $display("FAIL overwrite got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_clear_priority();
    do_key(13);
    do_key(1); do_key(10); do_key(2);
    PSW[13] = 1'b1;
    PSW[1]  = 1'b1;
    repeat (LAT) tick();
    model_key(13);
    PSW = '0;
    repeat (GAP) tick();
    checks++;
    if (obs_vec() !== exp_vec() || obs_vec() !== 19'd0) begin
      errors++;
      $display("FAIL clear_priority got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_glitch();
    do_key(13);
    PSW[5] = 1'b1;
    repeat (2) tick();
    PSW = '0;
    repeat (GAP) tick();
`ifndef CALC_DEBOUNCE_EN
    model_key(5);
`endif
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL glitch_2cyc got=%h exp=%h", obs_vec(), exp_vec());
    end
    do_key(13);
    PSW[5] = 1'b1;
    repeat (5) tick();
    PSW = '0;
    repeat (GAP) tick();
    model_key(5);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL hold_5cyc got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_held();
    PSW[4] = 1'b1;
    RST_X  = 1'b1;
    repeat (3) tick();
    RST_X = 1'b0;
    model_reset();
    repeat (20) tick();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL held_through_reset got=%h exp=%h", obs_vec(), exp_vec());
    end
    PSW = '0;
    repeat (GAP) tick();
    do_key(4);
    checks++;
    if (obs_vec() !== exp_vec() || dp.A_DATA !== 4'd4) begin
      errors++;
      $display("FAIL repress_after_reset got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_eval();
    do_key(13);
    do_key(7); do_key(10); do_key(6);
    PSW[12] = 1'b1;
    repeat (LAT) tick();
    checks++;
    if (STATE !== 3'd4) begin
      errors++;
      $display("FAIL reach_eval state got=%0d exp=4", STATE);
    end
    RST_X = 1'b1;
    tick();
    RST_X = 1'b0;
    PSW = '0;
    model_reset();
    repeat (GAP) tick();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_mid_eval got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    int r, k;
    do_key(13);
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 19);
      if (r < 10)      k = r;
      else if (r < 13) k = 10;
      else if (r < 16) k = 11;
      else if (r < 19) k = 12;
      else             k = 13;
      do_key(k);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_step%0d key=%0d got=%h exp=%h", n, k, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    RST_X = 1'b1;
    PSW   = '0;
    model_reset();
    test_reset();
    test_add();
    test_sub_and_restart();
    test_overwrite();
    test_clear_priority();
    test_glitch();
    test_reset_held();
    test_reset_eval();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
